// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending (scoreboard) bit for in-order issue.
// Reads are combinational with same-cycle writeback bypass; issue is refused on
// RAW hazards against pending sources and on WAW against a pending destination.
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs1_data,
    output logic [WIDTH-1:0]  rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_uses_rs2,
    output logic              stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic [ADDR_W:0]   pending_count
);

    localparam int              NREGS    = 2 ** ADDR_W;
    localparam bit              HAS_ZERO = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;

    logic rs1_zero, rs2_zero, rd_zero, wb_zero;
    logic rs1_byp, rs2_byp, rd_byp;
    logic waw, accept, set_en, cnt_up, cnt_dn;

    assign rs1_zero = HAS_ZERO && (rs1_addr == '0);
    assign rs2_zero = HAS_ZERO && (rs2_addr == '0);
    assign rd_zero  = HAS_ZERO && (issue_rd == '0);
    assign wb_zero  = HAS_ZERO && (wb_addr == '0);

    // A writeback landing this cycle satisfies any hazard on its register.
    assign rs1_byp = wb_valid && (wb_addr == rs1_addr);
    assign rs2_byp = wb_valid && (wb_addr == rs2_addr);
    assign rd_byp  = wb_valid && (wb_addr == issue_rd);

    assign rs1_data = rs1_zero ? '0 : (rs1_byp ? wb_data : regs[rs1_addr]);
    assign rs2_data = rs2_zero ? '0 : (rs2_byp ? wb_data : regs[rs2_addr]);

    assign rs1_busy = !rs1_zero && pending[rs1_addr] && !rs1_byp;
    assign rs2_busy = !rs2_zero && pending[rs2_addr] && !rs2_byp;

    assign waw    = pending[issue_rd] && !rd_byp;
    assign stall  = issue_valid && (rs1_busy || (issue_uses_rs2 && rs2_busy) || waw);
    assign accept = issue_valid && !stall;
    assign set_en = accept && !rd_zero;

    // Count moves only when the popcount really changes: a set on an already
    // pending register (possible only alongside its own writeback) adds nothing,
    // and a clear that is overridden by a same-register set removes nothing.
    assign cnt_up = set_en && !pending[issue_rd];
    assign cnt_dn = wb_valid && pending[wb_addr] && !(set_en && (issue_rd == wb_addr));

    // Scoreboard bits and their population counter; set is applied after clear so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            pending_count <= '0;
        end else begin
            if (wb_valid)
                pending[wb_addr] <= 1'b0;
            if (set_en)
                pending[issue_rd] <= 1'b1;
            if (cnt_up && !cnt_dn && (pending_count != CNT_MAX))
                pending_count <= pending_count + CNT_ONE;
            else if (cnt_dn && !cnt_up && (pending_count != '0))
                pending_count <= pending_count - CNT_ONE;
        end
    end

    // Register storage; writes to a hardwired zero register are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_valid && !wb_zero) begin
            regs[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus a random stream checked
// against a behavioural model; expected values travel through a queue.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, issue_valid, issue_uses_rs2, stall, wb_valid;
    logic [5:0]  pending_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    logic [31:0] mregs [32];
    logic [31:0] mpend;

    regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_uses_rs2(issue_uses_rs2), .stall(stall),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rs1_addr = 0; rs2_addr = 0; issue_valid = 0; issue_rd = 0;
        issue_uses_rs2 = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick();
        issue_valid = 1; issue_rd = 9; rs1_addr = 5; rs2_addr = 6; issue_uses_rs2 = 1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (rs1_data !== e) begin n_bad++; $display("FAIL reset_rs1_data: got %0h expected %0h", rs1_data, e); end
        n_cmp++; e = exp_q.pop_front();
        if (rs2_data !== e) begin n_bad++; $display("FAIL reset_rs2_data: got %0h expected %0h", rs2_data, e); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_busy !== e[0]) begin n_bad++; $display("FAIL reset_rs1_busy: got %0b expected %0b", rs1_busy, e[0]); end
        n_cmp++; e = exp_q.pop_front();
        if (stall !== e[0]) begin n_bad++; $display("FAIL reset_stall: got %0b expected %0b", stall, e[0]); end
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL reset_count: got %0d expected %0d", pending_count, e[5:0]); end
        tick();
        rst = 0; idle();
        exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL reset_priority_count: got %0d expected %0d", pending_count, e[5:0]); end
        tick();
    endtask

    task automatic test_wb_read();
        wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rs1_addr = 5;
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (rs1_data !== e) begin n_bad++; $display("FAIL wb_bypass: got %0h expected %0h", rs1_data, e); end
        tick();
        idle(); rs1_addr = 5;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (rs1_data !== e) begin n_bad++; $display("FAIL wb_stored: got %0h expected %0h", rs1_data, e); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_busy !== e[0]) begin n_bad++; $display("FAIL wb_busy: got %0b expected %0b", rs1_busy, e[0]); end
        tick();
    endtask

    task automatic test_zero_reg();
        idle(); wb_valid = 1; wb_addr = 0; wb_data = 32'h1234; rs2_addr = 0;
        exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (rs2_data !== e) begin n_bad++; $display("FAIL zero_same: got %0h expected %0h", rs2_data, e); end
        tick();
        idle(); rs2_addr = 0;
        exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (rs2_data !== e) begin n_bad++; $display("FAIL zero_next: got %0h expected %0h", rs2_data, e); end
        tick();
        issue_valid = 1; issue_rd = 0;
        tick();
        idle();
        exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL zero_count: got %0d expected %0d", pending_count, e[5:0]); end
        tick();
    endtask

    task automatic test_raw_bypass();
        idle(); issue_valid = 1; issue_rd = 7;
        exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (stall !== e[0]) begin n_bad++; $display("FAIL raw_first_issue: got %0b expected %0b", stall, e[0]); end
        tick();
        idle(); issue_valid = 1; issue_rd = 8; rs1_addr = 7;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (stall !== e[0]) begin n_bad++; $display("FAIL raw_stall: got %0b expected %0b", stall, e[0]); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_busy !== e[0]) begin n_bad++; $display("FAIL raw_busy: got %0b expected %0b", rs1_busy, e[0]); end
        wb_valid = 1; wb_addr = 7; wb_data = 32'hA5;
        exp_q.push_back(32'd0); exp_q.push_back(32'hA5);
        #1;
        n_cmp++; e = exp_q.pop_front();
        if (stall !== e[0]) begin n_bad++; $display("FAIL raw_wb_stall: got %0b expected %0b", stall, e[0]); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_data !== e) begin n_bad++; $display("FAIL raw_wb_data: got %0h expected %0h", rs1_data, e); end
        tick();
        idle(); rs1_addr = 8;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL raw_count: got %0d expected %0d", pending_count, e[5:0]); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_busy !== e[0]) begin n_bad++; $display("FAIL raw_x8_busy: got %0b expected %0b", rs1_busy, e[0]); end
        idle(); wb_valid = 1; wb_addr = 8; wb_data = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_waw();
        idle(); issue_valid = 1; issue_rd = 3;
        tick();
        idle(); issue_valid = 1; issue_rd = 3;
        exp_q.push_back(32'd1);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (stall !== e[0]) begin n_bad++; $display("FAIL waw_stall: got %0b expected %0b", stall, e[0]); end
        wb_valid = 1; wb_addr = 3; wb_data = 32'h33;
        exp_q.push_back(32'd0);
        #1;
        n_cmp++; e = exp_q.pop_front();
        if (stall !== e[0]) begin n_bad++; $display("FAIL waw_wb_stall: got %0b expected %0b", stall, e[0]); end
        tick();
        idle(); rs1_addr = 3;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'h33);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL waw_count: got %0d expected %0d", pending_count, e[5:0]); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_busy !== e[0]) begin n_bad++; $display("FAIL waw_still_pending: got %0b expected %0b", rs1_busy, e[0]); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_data !== e) begin n_bad++; $display("FAIL waw_data: got %0h expected %0h", rs1_data, e); end
        idle(); wb_valid = 1; wb_addr = 3; wb_data = 32'h0;
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            idle(); wb_valid = 1; wb_addr = 5'(i); wb_data = 32'h100 + 32'(i);
            tick();
        end
        for (int i = 1; i <= 4; i++) begin
            idle(); issue_valid = 1; issue_rd = 5'(i);
            tick();
            idle();
            exp_q.push_back(32'(i));
            @(negedge clk);
            n_cmp++; e = exp_q.pop_front();
            if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL b2b_count_%0d: got %0d expected %0d", i, pending_count, e[5:0]); end
        end
        tick();
        rst = 1;
        tick();
        rst = 0;
        exp_q.push_back(32'd0);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL b2b_reset_count: got %0d expected %0d", pending_count, e[5:0]); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            idle(); rs1_addr = 5'(i); rs2_addr = 5'(i);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            @(negedge clk);
            n_cmp++; e = exp_q.pop_front();
            if (rs1_data !== e) begin n_bad++; $display("FAIL b2b_reset_data_%0d: got %0h expected %0h", i, rs1_data, e); end
            n_cmp++; e = exp_q.pop_front();
            if (rs2_busy !== e[0]) begin n_bad++; $display("FAIL b2b_reset_busy_%0d: got %0b expected %0b", i, rs2_busy, e[0]); end
        end
        tick();
        idle(); wb_valid = 1; wb_addr = 2; wb_data = 32'h77;
        tick();
        idle(); rs1_addr = 2;
        exp_q.push_back(32'd0); exp_q.push_back(32'h77);
        @(negedge clk);
        n_cmp++; e = exp_q.pop_front();
        if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL stale_wb_count: got %0d expected %0d", pending_count, e[5:0]); end
        n_cmp++; e = exp_q.pop_front();
        if (rs1_data !== e) begin n_bad++; $display("FAIL stale_wb_data: got %0h expected %0h", rs1_data, e); end
        tick();
    endtask

    task automatic test_random();
        logic        b1, b2, waw, st;
        logic [31:0] e1, e2;
        rst = 1; idle();
        tick();
        rst = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        mpend = 32'd0;
        for (int c = 0; c < 400; c++) begin
            rs1_addr       = 5'($urandom_range(0, 7));
            rs2_addr       = 5'($urandom_range(0, 7));
            issue_valid    = ($urandom_range(0, 99) < 60);
            issue_rd       = 5'($urandom_range(0, 7));
            issue_uses_rs2 = $urandom_range(0, 1) == 1;
            wb_valid       = ($urandom_range(0, 99) < 45);
            wb_addr        = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            e1 = (rs1_addr == 0) ? 32'd0 : (wb_valid && wb_addr == rs1_addr) ? wb_data : mregs[rs1_addr];
            e2 = (rs2_addr == 0) ? 32'd0 : (wb_valid && wb_addr == rs2_addr) ? wb_data : mregs[rs2_addr];
            b1 = mpend[rs1_addr] && !(wb_valid && wb_addr == rs1_addr);
            b2 = mpend[rs2_addr] && !(wb_valid && wb_addr == rs2_addr);
            waw = mpend[issue_rd] && !(wb_valid && wb_addr == issue_rd);
            st = issue_valid && (b1 || (issue_uses_rs2 && b2) || waw);
            exp_q.push_back(e1); exp_q.push_back(e2);
            exp_q.push_back({31'd0, st}); exp_q.push_back(32'($countones(mpend)));
            @(negedge clk);
            n_cmp++; e = exp_q.pop_front();
            if (rs1_data !== e) begin n_bad++; $display("FAIL rand_rs1_data c%0d: got %0h expected %0h", c, rs1_data, e); end
            n_cmp++; e = exp_q.pop_front();
            if (rs2_data !== e) begin n_bad++; $display("FAIL rand_rs2_data c%0d: got %0h expected %0h", c, rs2_data, e); end
            n_cmp++; e = exp_q.pop_front();
            if (stall !== e[0]) begin n_bad++; $display("FAIL rand_stall c%0d: got %0b expected %0b", c, stall, e[0]); end
            n_cmp++; e = exp_q.pop_front();
            if (pending_count !== e[5:0]) begin n_bad++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, pending_count, e[5:0]); end
            if (wb_valid) begin
                if (wb_addr != 0) mregs[wb_addr] = wb_data;
                mpend[wb_addr] = 1'b0;
            end
            if (issue_valid && !st && issue_rd != 0) mpend[issue_rd] = 1'b1;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_zero_reg();
        test_raw_bypass();
        test_waw();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
